// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU and EX/MEM register.
// Optional iterative multiplier built when EX_MULT_EN is defined.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_stall,
  input  logic              flush,
  input  logic              id_ex_valid,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        alu_ctrl,
  input  logic              alu_src,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              ex_busy,
  output logic              ex_mem_valid,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic [REG_W-1:0]  ex_mem_write_reg,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic              ex_mem_mem_write,
  output logic              ex_mem_mem_to_reg,
  output logic              ex_mem_zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1010;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [REG_W-1:0]  wr_q, wr_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              m2r_q, m2r_d;
  logic              zero_q, zero_d;

  logic [DATA_W-1:0] fwd_a, fwd_b, op_b, alu_res;

  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic [DATA_W-1:0] mul_sd;
  logic [REG_W-1:0]  mul_wr;
  logic [3:0]        mul_ctl;

  // Operand forwarding; code 11 falls back to the register file
  always_comb begin
    fwd_a = rs_val;
    fwd_b = rt_val;
    case (forward_a)
      2'b01:   fwd_a = mem_wb_data;
      2'b10:   fwd_a = res_q;
      default: fwd_a = rs_val;
    endcase
    case (forward_b)
      2'b01:   fwd_b = mem_wb_data;
      2'b10:   fwd_b = res_q;
      default: fwd_b = rt_val;
    endcase
    op_b = alu_src ? imm : fwd_b;
  end

  // Single-cycle ALU; unknown codes (and MUL here) give 0
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_AND: alu_res = fwd_a & op_b;
      OP_OR:  alu_res = fwd_a | op_b;
      OP_ADD: alu_res = fwd_a + op_b;
      OP_SUB: alu_res = fwd_a - op_b;
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}},
                         $signed(fwd_a) < $signed(op_b)};
      OP_NOR: alu_res = ~(fwd_a | op_b);
      OP_SLL: alu_res = op_b << imm[10:6];
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULT_EN
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0] msd_q, msd_d;
  logic [REG_W-1:0]  mwr_q, mwr_d;
  logic [3:0]        mctl_q, mctl_d;
  logic              mul_req;

  assign mul_req  = id_ex_valid && (alu_ctrl == OP_MUL);
  assign mul_busy = (state_q == RUN) ||
                    ((state_q == IDLE) && mul_req);
  assign mul_done = (state_q == DONE);
  assign mul_prod = prod_q;
  assign mul_sd   = msd_q;
  assign mul_wr   = mwr_q;
  assign mul_ctl  = mctl_q;

  // Multiplier next state: capture at issue, shift-add in RUN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    msd_d    = msd_q;
    mwr_d    = mwr_q;
    mctl_d   = mctl_q;
    if (!mem_stall) begin
      if (flush) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: if (mul_req) begin
            state_d  = RUN;
            cnt_d    = '0;
            mcand_d  = fwd_a;
            mplier_d = op_b;
            prod_d   = '0;
            msd_d    = fwd_b;
            mwr_d    = write_reg_in;
            mctl_d   = {reg_write_in, mem_read_in,
                        mem_write_in, mem_to_reg_in};
          end
          RUN: begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(DATA_W - 1)) state_d = DONE;
          end
          DONE: state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      msd_q    <= '0;
      mwr_q    <= '0;
      mctl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      msd_q    <= msd_d;
      mwr_q    <= mwr_d;
      mctl_q   <= mctl_d;
    end
  end
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
  assign mul_sd   = '0;
  assign mul_wr   = '0;
  assign mul_ctl  = '0;
`endif

  assign ex_busy = mul_busy;

  // EX/MEM next value: hold on stall, bubble, product or ALU result
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    sd_d    = sd_q;
    wr_d    = wr_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    m2r_d   = m2r_q;
    zero_d  = zero_q;
    if (!mem_stall) begin
      if (flush || (mul_busy && !mul_done) ||
          (!mul_done && !id_ex_valid)) begin
        valid_d = 1'b0;
        rw_d    = 1'b0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        m2r_d   = 1'b0;
      end else if (mul_done) begin
        valid_d = 1'b1;
        res_d   = mul_prod;
        sd_d    = mul_sd;
        wr_d    = mul_wr;
        {rw_d, mr_d, mw_d, m2r_d} = mul_ctl;
        zero_d  = (mul_prod == '0);
      end else begin
        valid_d = 1'b1;
        res_d   = alu_res;
        sd_d    = fwd_b;
        wr_d    = write_reg_in;
        rw_d    = reg_write_in;
        mr_d    = mem_read_in;
        mw_d    = mem_write_in;
        m2r_d   = mem_to_reg_in;
        zero_d  = (alu_res == '0);
      end
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      sd_q    <= '0;
      wr_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      sd_q    <= sd_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      m2r_q   <= m2r_d;
      zero_q  <= zero_d;
    end
  end

  assign ex_mem_valid      = valid_q;
  assign ex_mem_alu_result = res_q;
  assign ex_mem_store_data = sd_q;
  assign ex_mem_write_reg  = wr_q;
  assign ex_mem_reg_write  = rw_q;
  assign ex_mem_mem_read   = mr_q;
  assign ex_mem_mem_write  = mw_q;
  assign ex_mem_mem_to_reg = m2r_q;
  assign ex_mem_zero       = zero_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS-style pipeline.
- Sits between the ID/EX register and the MEM stage, and consumes the ForwardA/ForwardB selects from the forwarding unit.
- Selects forwarded ALU operands, executes the ALU op, and registers results into the EX/MEM pipeline register.
- Contains an iterative multiplier FSM that stalls the front end while a multiply runs.

Parameters:
- DATA_W, 32, datapath width
- REG_W, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_stall  in  1  MEM stage not ready; freezes this stage
- flush  in  1  kill the instruction currently in EX (synchronous)
- id_ex_valid  in  1  ID/EX holds a real instruction
- rs_val  in  DATA_W  register-file value of source 1
- rt_val  in  DATA_W  register-file value of source 2
- imm  in  DATA_W  sign-extended immediate
- alu_ctrl  in  4  ALU operation
- alu_src  in  1  1: operand B = imm
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  control bits to carry forward
- write_reg_in  in  REG_W  destination register
- forward_a  in  2  operand A forward select
- forward_b  in  2  operand B forward select
- mem_wb_data  in  DATA_W  MEM/WB writeback value
- ex_busy  out  1  hold ID/EX and earlier stages
- ex_mem_valid  out  1  EX/MEM holds a real instruction
- ex_mem_alu_result  out  DATA_W  registered result
- ex_mem_store_data  out  DATA_W  registered forwarded rt value
- ex_mem_write_reg  out  REG_W  registered destination register
- ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg  out  1 each  registered control bits
- ex_mem_zero  out  1  registered result==0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All ex_mem_* outputs are 0.
  - FSM goes to IDLE.
  - Multiplier registers are 0.
  - ex_busy is 0.
- Forward mux, operand A (B identical, using forward_b and rt_val):
  - 00 = rs_val.
  - 01 = mem_wb_data.
  - 10 = ex_mem_alu_result (this block's own register).
  - 11 = rs_val.
- ALU operand B = imm if alu_src, else the forwarded B. Store data = forwarded B, before the alu_src mux.
- alu_ctrl encoding:
  - 0000 AND, 0001 OR, 0010 ADD (wraps mod 2^32), 0110 SUB (wraps).
  - 0111 SLT: signed compare, result 1 or 0.
  - 1100 NOR.
  - 1000 SLL: forwarded B << imm[10:6].
  - 1010 MUL: see Optional Feature.
  - Any other code gives result 0.
- Single-cycle ops: 1 cycle latency. The values presented in cycle N appear on ex_mem_* after edge N.
- Priority per edge: rst_n > mem_stall > flush > normal operation.
- mem_stall=1:
  - All EX/MEM registers and the FSM hold.
  - flush is ignored that cycle; the hazard controller holds flush until mem_stall drops.
- flush=1 (no stall):
  - EX/MEM loads a bubble: valid, reg_write, mem_read, mem_write and mem_to_reg all 0; data fields don't-care.
  - An in-progress multiply aborts and the FSM returns to IDLE.
- id_ex_valid=0: EX/MEM loads a bubble.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when id_ex_valid, alu_ctrl=MUL, no stall, no flush. Forwarded operands are captured; count is set to 0.
  - RUN: one shift-add step per unstalled cycle. After 32 steps → DONE.
  - DONE → IDLE on the next unstalled edge. EX/MEM loads the low 32 bits of the product with the captured control bits.
- ex_busy = (IDLE and MUL issuing) or RUN. ex_busy is 0 in DONE, so upstream advances on the same edge the product is written.
- EX/MEM loads bubbles during issue and RUN cycles.
- Issue-to-valid latency is 34 edges with no stall. Each mem_stall cycle adds one.
- The product is independent of forward inputs changing after issue, because operands are captured at issue.

Optional Feature:
- Macro: EX_MULT_EN.
- Defined: the multiplier FSM is built; MUL behaves as above.
- Undefined: no FSM is built; ex_busy is tied to 0; MUL is treated as an undefined op (result 0, single cycle, control bits still propagate).

Test Plan:
- ADD: rs_val=5, rt_val=7, forward 00/00, reg_write_in=1, write_reg_in=3 → after 1 edge: ex_mem_alu_result=12, ex_mem_write_reg=3, ex_mem_valid=1, ex_mem_zero=0.
- Forwarding: previous result 12 in EX/MEM, forward_a=10, forward_b=01, mem_wb_data=4, SUB → result 8. With forward_a=11 and rs_val=1 → result -3 (0xFFFFFFFD).
- SLT signed: A=0xFFFFFFFF, B=1 → 1. SLL: B=1, imm[10:6]=31 → 0x80000000.
- mem_stall held 3 cycles with new inputs presented → ex_mem_* unchanged. Release → new result on the next edge.
- EX_MULT_EN: MUL 0x10000×0x10001 → ex_busy high for 33 cycles, bubbles during them, ex_mem_alu_result=0x00010000 at edge 34. flush asserted at RUN count 10 → FSM IDLE, bubble, ex_busy=0 next cycle.
- Reset mid-multiply: rst_n low during RUN → all outputs 0 immediately (asynchronous), FSM IDLE, ex_busy=0.
